// File: rtl/ifid_skid_queue.sv
// IF/ID pipeline register with an in-order skid queue for fetch responses that return while decode is held.
// Build option: define IFID_HWM_EN to keep a queue-occupancy high-water mark on q_hwm (otherwise q_hwm is 0).
module ifid_skid_queue #(
  parameter int               XLEN   = 32,
  parameter int               DEPTH  = 2,
  parameter logic [XLEN-1:0]  BUBBLE = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         IM_stall,
  input  logic                         DM_stall,
  input  logic                         flush,
  input  logic                         F_valid,
  input  logic [XLEN-1:0]              F_pc,
  input  logic [XLEN-1:0]              F_inst,
  input  logic                         F_PredictTaken,
  output logic                         F_ready,
  output logic [XLEN-1:0]              D_pc,
  output logic [XLEN-1:0]              D_inst,
  output logic                         D_PredictTaken,
  output logic                         D_valid,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         q_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   q_hwm
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: F_valid is a response, not a request; it is never back-pressured.
  // F_ready only advertises free queue space. A valid response arriving while
  // the queue is full and decode is held is dropped and latched into q_ovf.

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic            mem_pt   [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          flush_pend;

  logic mem_stall, hold, eff_flush, full, empty;
  logic push, pop, ovf_set, d_load;
  logic [XLEN-1:0] nxt_pc, nxt_inst;
  logic            nxt_pt, nxt_valid;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mem_stall = IM_stall | DM_stall;
  assign hold      = stall | mem_stall;
  assign eff_flush = (flush | flush_pend) & ~mem_stall;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign F_ready   = ~full;
  assign q_count   = count;

  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    d_load    = 1'b0;
    nxt_pc    = '0;
    nxt_inst  = BUBBLE;
    nxt_pt    = 1'b0;
    nxt_valid = 1'b0;
    if (eff_flush) begin
      d_load = 1'b1;
    end else if (flush || flush_pend) begin
      // Flush waiting on a memory stall: everything frozen, fetches are wrong-path.
    end else if (hold) begin
      push    = F_valid & ~full;
      ovf_set = F_valid & full;
    end else begin
      d_load = 1'b1;
      if (!empty) begin
        pop       = 1'b1;
        push      = F_valid;
        nxt_pc    = mem_pc[head];
        nxt_inst  = mem_inst[head];
        nxt_pt    = mem_pt[head];
        nxt_valid = 1'b1;
      end else if (F_valid) begin
        nxt_pc    = F_pc;
        nxt_inst  = F_inst;
        nxt_pt    = F_PredictTaken;
        nxt_valid = 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]   <= F_pc;
      mem_inst[tail] <= F_inst;
      mem_pt[tail]   <= F_PredictTaken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      flush_pend     <= 1'b0;
      q_ovf          <= 1'b0;
      D_pc           <= '0;
      D_inst         <= BUBBLE;
      D_PredictTaken <= 1'b0;
      D_valid        <= 1'b0;
    end else begin
      if (d_load) begin
        D_pc           <= nxt_pc;
        D_inst         <= nxt_inst;
        D_PredictTaken <= nxt_pt;
        D_valid        <= nxt_valid;
      end
      if (eff_flush) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (flush) flush_pend <= 1'b1;
        if (pop)  head <= next_ptr(head);
        if (push) tail <= next_ptr(tail);
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (ovf_set) q_ovf <= 1'b1;
    end
  end

`ifdef IFID_HWM_EN
  logic [CW-1:0] hwm;

  always_ff @(posedge clk) begin
    if (rst) hwm <= '0;
    else if (count > hwm) hwm <= count;
  end

  assign q_hwm = hwm;
`else
  assign q_hwm = '0;
`endif

endmodule
